bfly_stage: RTL and testbench

- Radix-2 butterfly array for a pipelined FFT stage (DIF style).
- Each valid beat takes NUM_PAIR complex input lanes (din) and NUM_PAIR complex delayed lanes (shift_data), one per pair.
- Produces the registered full-precision sum and difference for every lane.
- Tracks which half of a 2*NUM_PAIR-beat block is active, so the downstream twiddle multiplier is only enabled for difference-half beats.

---
 rtl/bfly_stage_pkg.sv | 24 ++
 rtl/bfly_stage_if.sv | 31 +++
 rtl/bfly_stage_lane.sv | 40 ++++
 rtl/bfly_stage.sv | 64 ++++++
 tb/tb_bfly_stage.sv | 301 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bfly_stage_pkg.sv
// Shared constants, phase type and helpers for the radix-2 DIF butterfly stage.
// Imported by the interface, the lane and the top.
package bfly_stage_pkg;

    localparam int DEF_WIDTH    = 12;
    localparam int DEF_NUM_PAIR = 16;
    localparam int DEF_CNT_W    = $clog2(2 * DEF_NUM_PAIR);

    typedef enum logic {
        SUM_HALF  = 1'b0,
        DIFF_HALF = 1'b1
    } phase_t;

    // Beat counter width for a block of 2*np beats.
    function automatic int cnt_width(input int np);
        return $clog2(2 * np);
    endfunction

    // Treat the low w bits of v as a two's-complement value and sign-extend to 32 bits.
    function automatic logic signed [31:0] sext(input logic [31:0] v, input int w);
        return $signed(v << (32 - w)) >>> (32 - w);
    endfunction

endpackage

// File: rtl/bfly_stage_if.sv
// Beat bus of the butterfly stage: NUM_PAIR complex lanes in, registered
// sum/difference lanes and the twiddle enable out.
interface bfly_stage_if
    import bfly_stage_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_PAIR = DEF_NUM_PAIR
);

    logic                    bfly_valid;
    logic signed [WIDTH-1:0] din_re        [NUM_PAIR];
    logic signed [WIDTH-1:0] din_im        [NUM_PAIR];
    logic signed [WIDTH-1:0] shift_data_re [NUM_PAIR];
    logic signed [WIDTH-1:0] shift_data_im [NUM_PAIR];
    logic signed [WIDTH:0]   bfly_sum_re   [NUM_PAIR];
    logic signed [WIDTH:0]   bfly_sum_im   [NUM_PAIR];
    logic signed [WIDTH:0]   bfly_diff_re  [NUM_PAIR];
    logic signed [WIDTH:0]   bfly_diff_im  [NUM_PAIR];
    logic                    twiddle_valid;

    modport master (
        output bfly_valid, din_re, din_im, shift_data_re, shift_data_im,
        input  bfly_sum_re, bfly_sum_im, bfly_diff_re, bfly_diff_im, twiddle_valid
    );

    modport slave (
        input  bfly_valid, din_re, din_im, shift_data_re, shift_data_im,
        output bfly_sum_re, bfly_sum_im, bfly_diff_re, bfly_diff_im, twiddle_valid
    );

endinterface

// File: rtl/bfly_stage_lane.sv
// One complex butterfly lane: registered full-precision shift+din and shift-din,
// loaded only when en is high.
module bfly_lane
    import bfly_stage_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    en,
    input  logic signed [WIDTH-1:0] din_re,
    input  logic signed [WIDTH-1:0] din_im,
    input  logic signed [WIDTH-1:0] sh_re,
    input  logic signed [WIDTH-1:0] sh_im,
    output logic signed [WIDTH:0]   sum_re_p1,
    output logic signed [WIDTH:0]   sum_im_p1,
    output logic signed [WIDTH:0]   diff_re_p1,
    output logic signed [WIDTH:0]   diff_im_p1
);

    function automatic logic signed [WIDTH:0] ext(input logic signed [WIDTH-1:0] v);
        return (WIDTH + 1)'(sext({{(32 - WIDTH){1'b0}}, v}, WIDTH));
    endfunction

    // p0 -> p1: one extra bit of headroom makes every sum and difference exact
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_re_p1  <= '0;
            sum_im_p1  <= '0;
            diff_re_p1 <= '0;
            diff_im_p1 <= '0;
        end else if (en) begin
            sum_re_p1  <= ext(sh_re) + ext(din_re);
            sum_im_p1  <= ext(sh_im) + ext(din_im);
            diff_re_p1 <= ext(sh_re) - ext(din_re);
            diff_im_p1 <= ext(sh_im) - ext(din_im);
        end
    end

endmodule

// File: rtl/bfly_stage.sv
// Radix-2 DIF butterfly array: NUM_PAIR independent lanes plus a beat counter
// that flags the difference half of each 2*NUM_PAIR-beat block for the twiddle stage.
module bfly_stage
    import bfly_stage_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int NUM_PAIR = DEF_NUM_PAIR
) (
    input logic         clk,
    input logic         rst,
    bfly_stage_if.slave bus
);

    localparam int               CNT_W    = cnt_width(NUM_PAIR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * NUM_PAIR - 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(NUM_PAIR);

    logic [CNT_W-1:0]      cnt_p0;
    phase_t                phase_p0;
    logic                  vld_p1;
    logic signed [WIDTH:0] sum_re_p1  [NUM_PAIR];
    logic signed [WIDTH:0] sum_im_p1  [NUM_PAIR];
    logic signed [WIDTH:0] diff_re_p1 [NUM_PAIR];
    logic signed [WIDTH:0] diff_im_p1 [NUM_PAIR];

    always_comb begin
        phase_p0 = SUM_HALF;
        if (cnt_p0 >= CNT_HALF) phase_p0 = DIFF_HALF;
    end

    // p0 -> p1: counter only moves on valid beats, so gaps freeze the block position
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_p0 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= bus.bfly_valid && (phase_p0 == DIFF_HALF);
            if (bus.bfly_valid) cnt_p0 <= (cnt_p0 == CNT_LAST) ? '0 : cnt_p0 + CNT_W'(1);
        end
    end

    for (genvar i = 0; i < NUM_PAIR; i++) begin : g_lane
        bfly_lane #(.WIDTH(WIDTH)) u_lane (
            .clk        (clk),
            .rst        (rst),
            .en         (bus.bfly_valid),
            .din_re     (bus.din_re[i]),
            .din_im     (bus.din_im[i]),
            .sh_re      (bus.shift_data_re[i]),
            .sh_im      (bus.shift_data_im[i]),
            .sum_re_p1  (sum_re_p1[i]),
            .sum_im_p1  (sum_im_p1[i]),
            .diff_re_p1 (diff_re_p1[i]),
            .diff_im_p1 (diff_im_p1[i])
        );
    end

    assign bus.bfly_sum_re   = sum_re_p1;
    assign bus.bfly_sum_im   = sum_im_p1;
    assign bus.bfly_diff_re  = diff_re_p1;
    assign bus.bfly_diff_im  = diff_im_p1;
    assign bus.twiddle_valid = vld_p1;

endmodule

// File: tb/tb_bfly_stage.sv
// Self-checking bench for bfly_stage: directed block scenarios plus randomized
// beats against a behavioural model of sums, differences and block position.
module tb_bfly_stage;
    import bfly_stage_pkg::*;

    localparam int W  = 12;
    localparam int NP = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    bfly_stage_if #(.WIDTH(W), .NUM_PAIR(NP)) bus ();

    bfly_stage #(.WIDTH(W), .NUM_PAIR(NP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    // Behavioural model: valid beats since reset (mod 2*NP) and the held outputs.
    int beats = 0;
    int m_sum_re [NP];
    int m_sum_im [NP];
    int m_dif_re [NP];
    int m_dif_im [NP];
    bit m_tw = 1'b0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        beats = 0;
        m_tw  = 1'b0;
        for (int i = 0; i < NP; i++) begin
            m_sum_re[i] = 0; m_sum_im[i] = 0; m_dif_re[i] = 0; m_dif_im[i] = 0;
        end
    endtask

    // Drive one beat from per-lane values and update the model with it.
    task automatic apply(input bit v, input int dre[NP], input int dim[NP],
                         input int sre[NP], input int sim[NP]);
        bus.bfly_valid = v;
        for (int i = 0; i < NP; i++) begin
            bus.din_re[i]        = W'(dre[i]);
            bus.din_im[i]        = W'(dim[i]);
            bus.shift_data_re[i] = W'(sre[i]);
            bus.shift_data_im[i] = W'(sim[i]);
        end
        if (!rst) begin
            m_tw = v && (beats >= NP);
            if (v) begin
                for (int i = 0; i < NP; i++) begin
                    m_sum_re[i] = sre[i] + dre[i];
                    m_sum_im[i] = sim[i] + dim[i];
                    m_dif_re[i] = sre[i] - dre[i];
                    m_dif_im[i] = sim[i] - dim[i];
                end
                beats = (beats + 1) % (2 * NP);
            end
        end
    endtask

    // Same value on every lane, with the real parts offset by lane*step.
    task automatic drive(input bit v, input int dre, input int dim,
                         input int sre, input int sim, input int step);
        int a[NP], b[NP], c[NP], d[NP];
        for (int i = 0; i < NP; i++) begin
            a[i] = dre + i * step; b[i] = dim; c[i] = sre + i * step; d[i] = sim;
        end
        apply(v, a, b, c, d);
    endtask

    task automatic drive_rand(input bit v);
        int a[NP], b[NP], c[NP], d[NP];
        for (int i = 0; i < NP; i++) begin
            a[i] = int'($urandom_range(0, 4095)) - 2048;
            b[i] = int'($urandom_range(0, 4095)) - 2048;
            c[i] = int'($urandom_range(0, 4095)) - 2048;
            d[i] = int'($urandom_range(0, 4095)) - 2048;
        end
        apply(v, a, b, c, d);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive_rand(1'b1);
        tick();
        tick();
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < NP; i++) begin
            total++;
            if (bus.bfly_sum_re[i] !== '0 || bus.bfly_sum_im[i] !== '0 ||
                bus.bfly_diff_re[i] !== '0 || bus.bfly_diff_im[i] !== '0) begin
                bad++;
                $display("FAIL reset lane %0d: got %0d/%0d/%0d/%0d want all 0", i,
                         bus.bfly_sum_re[i], bus.bfly_sum_im[i], bus.bfly_diff_re[i], bus.bfly_diff_im[i]);
            end
        end
        total++;
        if (bus.twiddle_valid !== 1'b0) begin
            bad++;
            $display("FAIL reset twiddle_valid: got %b want 0", bus.twiddle_valid);
        end
    endtask

    task automatic test_idle();
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 11 * k, 7 * k, 3 * k, 5 * k, 1);
            tick();
            for (int i = 0; i < NP; i++) begin
                total++;
                if (bus.bfly_sum_re[i] !== '0 || bus.bfly_sum_im[i] !== '0 ||
                    bus.bfly_diff_re[i] !== '0 || bus.bfly_diff_im[i] !== '0) begin
                    bad++;
                    $display("FAIL idle lane %0d cycle %0d: got %0d/%0d/%0d/%0d want all 0", i, k,
                             bus.bfly_sum_re[i], bus.bfly_sum_im[i], bus.bfly_diff_re[i], bus.bfly_diff_im[i]);
                end
            end
            total++;
            if (bus.twiddle_valid !== 1'b0) begin
                bad++;
                $display("FAIL idle twiddle_valid cycle %0d: got %b want 0", k, bus.twiddle_valid);
            end
        end
    endtask

    // One half-block of valid beats; base values follow the directed plan.
    task automatic test_half(input string name, input int dre0, input int dim0,
                             input int sre0, input int sim0, input bit tw_exp);
        for (int k = 0; k < NP; k++) begin
            drive(1'b1, dre0 + k, dim0 + k, sre0 + k, sim0 + k, 1);
            tick();
            for (int i = 0; i < NP; i++) begin
                total++;
                if (bus.bfly_sum_re[i] !== 13'(sre0 + dre0 + 2 * k + 2 * i) ||
                    bus.bfly_sum_im[i] !== 13'(sim0 + dim0 + 2 * k) ||
                    bus.bfly_diff_re[i] !== 13'(sre0 - dre0) ||
                    bus.bfly_diff_im[i] !== 13'(sim0 - dim0)) begin
                    bad++;
                    $display("FAIL %s lane %0d beat %0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d",
                             name, i, k, bus.bfly_sum_re[i], bus.bfly_sum_im[i],
                             bus.bfly_diff_re[i], bus.bfly_diff_im[i],
                             sre0 + dre0 + 2 * k + 2 * i, sim0 + dim0 + 2 * k, sre0 - dre0, sim0 - dim0);
                end
            end
            total++;
            if (bus.twiddle_valid !== tw_exp) begin
                bad++;
                $display("FAIL %s twiddle_valid beat %0d: got %b want %b", name, k, bus.twiddle_valid, tw_exp);
            end
        end
    endtask

    task automatic test_sum_half();
        test_half("sum_half", 30, 130, 40, 230, 1'b0);
    endtask

    task automatic test_hold();
        for (int k = 0; k < 16; k++) begin
            drive(1'b0, 50 + k, 150 + k, 60 + k, 250 + k, 1);
            tick();
            for (int i = 0; i < NP; i++) begin
                total++;
                if (bus.bfly_sum_re[i] !== 13'(100 + 2 * i) || bus.bfly_sum_im[i] !== 13'(390) ||
                    bus.bfly_diff_re[i] !== 13'(10) || bus.bfly_diff_im[i] !== 13'(100)) begin
                    bad++;
                    $display("FAIL hold lane %0d cycle %0d: got %0d/%0d/%0d/%0d want %0d/390/10/100", i, k,
                             bus.bfly_sum_re[i], bus.bfly_sum_im[i], bus.bfly_diff_re[i],
                             bus.bfly_diff_im[i], 100 + 2 * i);
                end
            end
            total++;
            if (bus.twiddle_valid !== 1'b0) begin
                bad++;
                $display("FAIL hold twiddle_valid cycle %0d: got %b want 0", k, bus.twiddle_valid);
            end
        end
    endtask

    task automatic test_diff_half();
        test_half("diff_half", 70, 170, 80, 270, 1'b1);
        drive(1'b0, 1, 2, 3, 4, 1);
        tick();
        total++;
        if (bus.twiddle_valid !== 1'b0) begin
            bad++;
            $display("FAIL diff_half twiddle_valid after block: got %b want 0", bus.twiddle_valid);
        end
    endtask

    task automatic test_extremes();
        int dv[2] = '{-2048, 2047};
        int sv[2] = '{2047, -2048};
        int de[2] = '{4095, -4095};
        for (int t = 0; t < 2; t++) begin
            drive(1'b1, dv[t], dv[t], sv[t], sv[t], 0);
            tick();
            for (int i = 0; i < NP; i++) begin
                total++;
                if (bus.bfly_sum_re[i] !== 13'(-1) || bus.bfly_sum_im[i] !== 13'(-1) ||
                    bus.bfly_diff_re[i] !== 13'(de[t]) || bus.bfly_diff_im[i] !== 13'(de[t])) begin
                    bad++;
                    $display("FAIL extremes lane %0d case %0d: got %0d/%0d/%0d/%0d want -1/-1/%0d/%0d", i, t,
                             bus.bfly_sum_re[i], bus.bfly_sum_im[i], bus.bfly_diff_re[i],
                             bus.bfly_diff_im[i], de[t], de[t]);
                end
            end
            // Counter wrapped after the diff half, so these are sum-half beats 0 and 1.
            total++;
            if (bus.twiddle_valid !== 1'b0) begin
                bad++;
                $display("FAIL extremes twiddle_valid case %0d: got %b want 0", t, bus.twiddle_valid);
            end
        end
    endtask

    task automatic test_reset_midblock();
        int guard = 0;
        while (beats != NP + 5 && guard < 4 * NP) begin
            drive_rand(1'b1);
            tick();
            guard++;
        end
        total++;
        if (bus.twiddle_valid !== 1'b1) begin
            bad++;
            $display("FAIL midblock pre-reset twiddle_valid: got %b want 1", bus.twiddle_valid);
        end
        rst = 1'b1;
        drive_rand(1'b1);
        tick();
        rst = 1'b0;
        model_reset();
        total++;
        if (bus.twiddle_valid !== 1'b0 || bus.bfly_sum_re[3] !== '0 || bus.bfly_diff_im[9] !== '0) begin
            bad++;
            $display("FAIL midblock reset: got tw=%b sum_re3=%0d diff_im9=%0d want 0/0/0",
                     bus.twiddle_valid, bus.bfly_sum_re[3], bus.bfly_diff_im[9]);
        end
        for (int j = 0; j < 2 * NP; j++) begin
            drive_rand(1'b1);
            tick();
            total++;
            if (bus.twiddle_valid !== (j >= NP)) begin
                bad++;
                $display("FAIL midblock twiddle_valid beat %0d: got %b want %b", j, bus.twiddle_valid, j >= NP);
            end
            for (int i = 0; i < NP; i++) begin
                total++;
                if (bus.bfly_sum_re[i] !== 13'(m_sum_re[i]) || bus.bfly_diff_re[i] !== 13'(m_dif_re[i])) begin
                    bad++;
                    $display("FAIL midblock lane %0d beat %0d: got %0d/%0d want %0d/%0d", i, j,
                             bus.bfly_sum_re[i], bus.bfly_diff_re[i], m_sum_re[i], m_dif_re[i]);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            drive_rand($urandom_range(0, 9) < 7);
            tick();
            total++;
            if (bus.twiddle_valid !== m_tw) begin
                bad++;
                $display("FAIL random twiddle_valid cycle %0d: got %b want %b", c, bus.twiddle_valid, m_tw);
            end
            for (int i = 0; i < NP; i++) begin
                total++;
                if (bus.bfly_sum_re[i] !== 13'(m_sum_re[i]) || bus.bfly_sum_im[i] !== 13'(m_sum_im[i]) ||
                    bus.bfly_diff_re[i] !== 13'(m_dif_re[i]) || bus.bfly_diff_im[i] !== 13'(m_dif_im[i])) begin
                    bad++;
                    $display("FAIL random lane %0d cycle %0d: got %0d/%0d/%0d/%0d want %0d/%0d/%0d/%0d", i, c,
                             bus.bfly_sum_re[i], bus.bfly_sum_im[i], bus.bfly_diff_re[i], bus.bfly_diff_im[i],
                             m_sum_re[i], m_sum_im[i], m_dif_re[i], m_dif_im[i]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle();
        test_sum_half();
        test_hold();
        test_diff_half();
        test_extremes();
        test_reset_midblock();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
